lmem_arbiter: RTL

LMEM_ARBITER -- requirements
Module: lmem_arbiter

---
 rtl/conv_pkg.sv | 27 ++
 rtl/lmem_rr_pick.sv | 27 ++
 rtl/lmem_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the layer-memory arbiter slice.
// Holds the address/data widths, the valid bank-select codes, the arbiter
// state encoding and a small helper that classifies a bank select.
package conv_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam int SEL_W  = 3;

    // Valid layer-memory banks; anything outside CSEL_L1..CSEL_L5 is illegal.
    localparam logic [SEL_W-1:0] CSEL_L1 = 3'b001;
    localparam logic [SEL_W-1:0] CSEL_L2 = 3'b010;
    localparam logic [SEL_W-1:0] CSEL_L3 = 3'b011;
    localparam logic [SEL_W-1:0] CSEL_L4 = 3'b100;
    localparam logic [SEL_W-1:0] CSEL_L5 = 3'b101;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_OWN = 1'b1
    } arb_state_t;

    // True when the select addresses one of the existing banks.
    function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
        return (sel >= CSEL_L1) && (sel <= CSEL_L5);
    endfunction

endpackage

// File: rtl/lmem_rr_pick.sv
// Two-way round-robin pick.
// Ports:
//   i_req0, i_req1  requests competing for ownership
//   i_last_owner    requester that owned the port most recently
//   o_winner        requester that should become owner (0 or 1)
// On a tie the requester that did not own last wins; a single request
// always wins; with no request the output is don't-care (driven 0).
module lmem_rr_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_winner
);

    // Tie goes to whoever did not hold the port last.
    always_comb begin
        o_winner = 1'b0;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last_owner;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end else begin
            o_winner = 1'b0;
        end
    end

endmodule

// File: rtl/lmem_arbiter.sv
// Two-requester arbiter in front of the layer memories.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_reqN/i_lockN/i_weN       command request, ownership lock, write flag
//   i_selN/i_addrN/i_wdataN    bank select, word address, write data
//   o_gntN                     combinational accept of requester N's command
//   o_rvalidN/o_rdataN         registered read return for requester N
//   o_cwr/o_caddr_wr/o_cdata_wr  registered memory write port
//   o_crd/o_caddr_rd           registered memory read port
//   i_cdata_rd                 memory read data, sampled the cycle o_crd is high
//   o_csel                     registered bank select
//   o_err                      one-cycle pulse for an accepted command with bad select
module lmem_arbiter
    import conv_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req0,
    input  logic              i_lock0,
    input  logic              i_we0,
    input  logic [SEL_W-1:0]  i_sel0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_lock1,
    input  logic              i_we1,
    input  logic [SEL_W-1:0]  i_sel1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_cwr,
    output logic [ADDR_W-1:0] o_caddr_wr,
    output logic [DATA_W-1:0] o_cdata_wr,
    output logic              o_crd,
    output logic [ADDR_W-1:0] o_caddr_rd,
    input  logic [DATA_W-1:0] i_cdata_rd,
    output logic [SEL_W-1:0]  o_csel,
    output logic              o_err
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t        r_state, w_state_nxt;
    logic              r_owner, w_owner_nxt;
    logic              r_last_owner, w_last_owner_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_winner;
    logic              w_own_req, w_own_lock, w_oth_req;
    logic              w_we;
    logic [SEL_W-1:0]  w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_acc;
    logic              r_rd_id;

    lmem_rr_pick u_pick (
        .i_req0       (i_req0),
        .i_req1       (i_req1),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner)
    );

    // Route the current owner's command and the competitor's request.
    always_comb begin
        w_own_req  = i_req0;
        w_own_lock = i_lock0;
        w_oth_req  = i_req1;
        w_we       = i_we0;
        w_sel      = i_sel0;
        w_addr     = i_addr0;
        w_wdata    = i_wdata0;
        if (r_owner) begin
            w_own_req  = i_req1;
            w_own_lock = i_lock1;
            w_oth_req  = i_req0;
            w_we       = i_we1;
            w_sel      = i_sel1;
            w_addr     = i_addr1;
            w_wdata    = i_wdata1;
        end else begin
            w_own_req  = i_req0;
        end
    end

    // Ownership FSM: next state, burst count and grants.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_cnt_nxt        = r_cnt;
        o_gnt0           = 1'b0;
        o_gnt1           = 1'b0;
        case (r_state)
            ST_ARB: begin
                w_cnt_nxt = {CNT_W{1'b0}};
                if (i_req0 || i_req1) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_winner;
                end else begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_OWN: begin
                o_gnt0 = i_req0 & ~r_owner;
                o_gnt1 = i_req1 & r_owner;
                if (w_own_req && (r_cnt != CNT_MAX)) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_nxt = r_cnt;
                end
                // The count includes this cycle's accept, so the last burst
                // command and the handover decision happen together.
                if (!w_own_req && !w_own_lock) begin
                    w_state_nxt      = ST_ARB;
                    w_last_owner_nxt = r_owner;
                end else if ((w_cnt_nxt == CNT_MAX) && w_oth_req) begin
                    w_state_nxt      = ST_ARB;
                    w_last_owner_nxt = r_owner;
                end else begin
                    w_state_nxt = ST_OWN;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign w_acc = o_gnt0 | o_gnt1;

    // FSM state, owner, round-robin history and burst counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_ARB;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= {CNT_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Memory port: strobes last one cycle, address/data hold between commands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_cwr      <= 1'b0;
            o_crd      <= 1'b0;
            o_csel     <= {SEL_W{1'b0}};
            o_err      <= 1'b0;
            o_caddr_wr <= {ADDR_W{1'b0}};
            o_cdata_wr <= {DATA_W{1'b0}};
            o_caddr_rd <= {ADDR_W{1'b0}};
            r_rd_id    <= 1'b0;
        end else begin
            o_cwr  <= 1'b0;
            o_crd  <= 1'b0;
            o_csel <= {SEL_W{1'b0}};
            o_err  <= 1'b0;
            if (w_acc) begin
                if (sel_valid(w_sel)) begin
                    o_csel <= w_sel;
                    if (w_we) begin
                        o_cwr      <= 1'b1;
                        o_caddr_wr <= w_addr;
                        o_cdata_wr <= w_wdata;
                    end else begin
                        o_crd      <= 1'b1;
                        o_caddr_rd <= w_addr;
                        r_rd_id    <= r_owner;
                    end
                end else begin
                    o_err <= 1'b1;
                end
            end
        end
    end

    // Read return: capture memory data in the strobe cycle, steer by issuer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
            o_rdata0  <= {DATA_W{1'b0}};
            o_rdata1  <= {DATA_W{1'b0}};
        end else begin
            o_rvalid0 <= o_crd & ~r_rd_id;
            o_rvalid1 <= o_crd & r_rd_id;
            if (o_crd && !r_rd_id) begin
                o_rdata0 <= i_cdata_rd;
            end
            if (o_crd && r_rd_id) begin
                o_rdata1 <= i_cdata_rd;
            end
        end
    end

endmodule
